// File: rtl/ysyx_24080006_clint.sv
// ysyx_24080006_clint -- AXI4 responder for the core-local interruptor window.
// Holds a free-running 64-bit mtime counter, readable and writable as two
// 32-bit words at MTIME_LO (low half) and MTIME_LO+4 (high half). Any other
// word in the window reads as 0 with SLVERR and ignores writes with SLVERR.
// Ports:
//   clock, reset_n             clock, asynchronous active-low reset
//   aw*/w*/b*                  AXI4 write address / data / response channels
//   ar*/r*                     AXI4 read address / data channels
// Only 32-bit transfers (size 3'b010) with FIXED or INCR bursts are handled;
// the read and write channels run independent state machines.
module ysyx_24080006_clint #(
  parameter int unsigned DIV      = 1,
  parameter logic [31:0] MTIME_LO = 32'h0200BFF8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam logic [31:0] MTIME_HI  = MTIME_LO + 32'd4;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;
  localparam logic [1:0]  BURST_INC = 2'b01;

  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  rstate_e     rstate_q;
  wstate_e     wstate_q;
  logic [63:0] mtime_q, mtime_d;
  logic [31:0] presc_q, presc_d;
  logic        tick;

  // read channel state
  logic [29:0] raddr_q, raddr_nxt;
  logic [1:0]  rburst_q;
  logic [7:0]  rlen_q, rbeat_q;
  logic [63:0] snap_q;
  logic        arready_q, rvalid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;

  // write channel state
  logic [29:0] waddr_q, waddr_nxt;
  logic [1:0]  wburst_q;
  logic        werr_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;
  logic        wr_beat, hit_lo, hit_hi;

  logic unused_ok;
  assign unused_ok = ^{awlen, awsize, arsize, awaddr[1:0], araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // {data, resp} for one read beat at word address wa from snapshot s
  function automatic logic [33:0] rd_word(input logic [29:0] wa, input logic [63:0] s);
    if (wa == MTIME_LO[31:2])      return {s[31:0], RESP_OKAY};
    else if (wa == MTIME_HI[31:2]) return {s[63:32], RESP_OKAY};
    else                           return {32'h0, RESP_SLV};
  endfunction

  // ---------------- mtime and prescaler ----------------
  assign tick    = (presc_q == 32'(DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 32'd1;

  assign wr_beat = (wstate_q == W_DATA) && wvalid && wready_q;
  assign hit_lo  = (waddr_q == MTIME_LO[31:2]);
  assign hit_hi  = (waddr_q == MTIME_HI[31:2]);

  // A write hit replaces the increment for that cycle; the prescaler keeps going.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_beat && hit_lo)      mtime_d[31:0]  = merge(mtime_q[31:0], wdata, wstrb);
    else if (wr_beat && hit_hi) mtime_d[63:32] = merge(mtime_q[63:32], wdata, wstrb);
    else if (tick)              mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q <= '0;
      presc_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
    end
  end

  // ---------------- read channel ----------------
  assign raddr_nxt = (rburst_q == BURST_INC) ? raddr_q + 30'd1 : raddr_q;

  // Beat 0 is decoded straight from the live counter at AR acceptance (the
  // same value stored as the snapshot); later beats decode from the snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rburst_q  <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      snap_q    <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            raddr_q              <= araddr[31:2];
            rburst_q             <= arburst;
            rid_q                <= arid;
            rlen_q               <= arlen;
            rbeat_q              <= '0;
            snap_q               <= mtime_q;
            {rdata_q, rresp_q}   <= rd_word(araddr[31:2], mtime_q);
            rlast_q              <= (arlen == 8'd0);
            arready_q            <= 1'b0;
            rvalid_q             <= 1'b1;
            rstate_q             <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            raddr_q <= raddr_nxt;
            rbeat_q <= rbeat_q + 8'd1;
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              {rdata_q, rresp_q} <= rd_word(raddr_nxt, snap_q);
              rlast_q            <= ((rbeat_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  assign waddr_nxt = (wburst_q == BURST_INC) ? waddr_q + 30'd1 : waddr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            waddr_q   <= awaddr[31:2];
            wburst_q  <= awburst;
            bid_q     <= awid;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready_q) begin
            waddr_q <= waddr_nxt;
            if (!(hit_lo || hit_hi)) werr_q <= 1'b1;
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || !(hit_lo || hit_hi)) ? RESP_SLV : RESP_OKAY;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

endmodule

// File: tb/tb_ysyx_24080006_clint.sv
module tb_ysyx_24080006_clint;

  localparam logic [31:0] LO  = 32'h0200BFF8;
  localparam logic [31:0] HI  = 32'h0200BFFC;
  localparam logic [1:0]  INC = 2'b01;
  localparam logic [1:0]  FIX = 2'b00;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 1, arvalid = 0, rready = 0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  awid = '0, arid = '0, wstrb = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'b010, arsize = 3'b010;
  logic [1:0]  awburst = INC, arburst = INC;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  // second instance with DIV=3, read channel only
  logic        arvalid2 = 0;
  logic        awready2, wready2, bvalid2, arready2, rvalid2, rlast2;
  logic [3:0]  bid2, rid2;
  logic [1:0]  bresp2, rresp2;
  logic [31:0] rdata2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_24080006_clint #(.DIV(1), .MTIME_LO(32'h0200BFF8)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  ysyx_24080006_clint #(.DIV(3), .MTIME_LO(32'h0200BFF8)) u_div3 (
    .clock(clock), .reset_n(reset_n),
    .awvalid(1'b0), .awready(awready2), .awaddr(32'h0), .awid(4'h0), .awlen(8'h0),
    .awsize(3'b010), .awburst(2'b01),
    .wvalid(1'b0), .wready(wready2), .wdata(32'h0), .wstrb(4'h0), .wlast(1'b0),
    .bvalid(bvalid2), .bready(1'b1), .bid(bid2), .bresp(bresp2),
    .arvalid(arvalid2), .arready(arready2), .araddr(LO), .arid(4'h3), .arlen(8'h0),
    .arsize(3'b010), .arburst(2'b01),
    .rvalid(rvalid2), .rready(1'b1), .rid(rid2), .rdata(rdata2), .rresp(rresp2), .rlast(rlast2)
  );

  // ---------------- reference model of mtime ----------------
  logic [63:0] mt, mt3;
  logic [31:0] p3;
  logic [31:0] w_cur_addr = '0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mt <= '0;
    else if (wvalid && wready && ({w_cur_addr[31:2], 2'b00} == LO))
      mt <= {mt[63:32], bmerge(mt[31:0], wdata, wstrb)};
    else if (wvalid && wready && ({w_cur_addr[31:2], 2'b00} == HI))
      mt <= {bmerge(mt[63:32], wdata, wstrb), mt[31:0]};
    else mt <= mt + 64'd1;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p3  <= '0;
      mt3 <= '0;
    end else if (p3 == 32'd2) begin
      p3  <= '0;
      mt3 <= mt3 + 64'd1;
    end else p3 <= p3 + 32'd1;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;
  rexp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive AR, push the expected beats computed from the model, end at the
  // negedge where the first R beat is due.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    logic [63:0] snap;
    logic [31:0] a;
    rexp_t e;
    @(negedge clock);
    araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clock); n++; end
    if (!arready) begin
      chk("ar_timeout", {63'h0, arready}, 64'd1);
      arvalid = 1'b0;
      return;
    end
    snap = mt;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      if ({a[31:2], 2'b00} == LO)      begin e.data = snap[31:0];  e.resp = 2'b00; end
      else if ({a[31:2], 2'b00} == HI) begin e.data = snap[63:32]; e.resp = 2'b00; end
      else                             begin e.data = 32'h0;       e.resp = 2'b10; end
      e.last = (b == int'(len));
      e.id   = id;
      sb.push_back(e);
      if (burst == INC) a = a + 32'd4;
    end
    @(posedge clock);
    #1 arvalid = 1'b0;
    @(negedge clock);
  endtask

  task automatic collect(input int nbeats);
    int n;
    rexp_t e;
    rready = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      if (!rvalid || sb.size() == 0) begin
        chk("r_timeout", {63'h0, rvalid}, 64'd1);
        return;
      end
      e = sb.pop_front();
      chk("rdata", {32'h0, rdata}, {32'h0, e.data});
      chk("rresp", {62'h0, rresp}, {62'h0, e.resp});
      chk("rlast", {63'h0, rlast}, {63'h0, e.last});
      chk("rid",   {60'h0, rid},   {60'h0, e.id});
      @(negedge clock);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
    int n;
    @(negedge clock);
    awaddr = addr; awid = id; awlen = 8'd0; awburst = INC; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clock); n++; end
    if (!awready) begin
      chk("aw_timeout", {63'h0, awready}, 64'd1);
      awvalid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 awvalid = 1'b0;
    w_cur_addr = addr; wdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clock);
    n = 0;
    while (!wready && n < 50) begin @(negedge clock); n++; end
    if (!wready) begin
      chk("w_timeout", {63'h0, wready}, 64'd1);
      wvalid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 wvalid = 1'b0; wlast = 1'b0;
    @(negedge clock);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    chk("bvalid", {63'h0, bvalid}, 64'd1);
    chk("bresp", {62'h0, bresp}, {62'h0, exp_resp});
    chk("bid",   {60'h0, bid},   {60'h0, id});
  endtask

  task automatic read_div3(input int delay);
    int n;
    logic [63:0] snap;
    repeat (delay) @(negedge clock);
    @(negedge clock);
    arvalid2 = 1'b1;
    n = 0;
    while (!arready2 && n < 50) begin @(negedge clock); n++; end
    snap = mt3;
    @(posedge clock);
    #1 arvalid2 = 1'b0;
    @(negedge clock);
    n = 0;
    while (!rvalid2 && n < 50) begin @(negedge clock); n++; end
    chk("div3_rdata", {32'h0, rdata2}, {32'h0, snap[31:0]});
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_arready", {63'h0, arready}, 64'd0);
    chk("rst_rvalid",  {63'h0, rvalid},  64'd0);
    chk("rst_awready", {63'h0, awready}, 64'd0);
    chk("rst_wready",  {63'h0, wready},  64'd0);
    chk("rst_bvalid",  {63'h0, bvalid},  64'd0);
    chk("rst_rdata",   {32'h0, rdata},   64'd0);
    chk("rst_resps",   {60'h0, bresp, rresp}, 64'd0);
    chk("rst_ids",     {56'h0, bid, rid}, 64'd0);
    reset_n = 1'b1;

    // T1: single-beat low-word read
    repeat (8) @(negedge clock);
    do_read(LO, 4'h1, 8'd0, INC);
    collect(1);

    // T2: high-word write then read back
    do_write(HI, 4'h5, 32'h0000_0001, 4'hF, 2'b00);
    do_read(HI, 4'h2, 8'd0, INC);
    collect(1);

    // T3: two-beat INCR read from one snapshot
    do_read(LO, 4'h7, 8'd1, INC);
    collect(2);

    // FIXED burst stays on the low word
    do_read(LO, 4'h8, 8'd2, FIX);
    collect(3);

    // T4: unmapped read and write
    do_read(32'h0200_0000, 4'h9, 8'd0, INC);
    collect(1);
    do_write(32'h0200_0004, 4'hA, 32'hDEAD_BEEF, 4'hF, 2'b10);
    do_read(LO, 4'hB, 8'd0, INC);
    collect(1);

    // T5: single-byte write to the low word
    do_write(LO, 4'hC, 32'h0000_00AB, 4'h1, 2'b00);
    do_read(LO, 4'hD, 8'd1, INC);
    collect(2);

    // full low-word overwrite near the carry boundary
    do_write(LO, 4'h6, 32'hFFFF_FFF0, 4'hF, 2'b00);
    repeat (20) @(negedge clock);
    do_read(LO, 4'h4, 8'd1, INC);
    collect(2);

    // T6: back-pressure hold
    rready = 1'b0;
    do_read(LO, 4'hE, 8'd1, INC);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {63'h0, rvalid}, 64'd1);
      chk("hold_rdata",  {32'h0, rdata},  {32'h0, sb[0].data});
      chk("hold_rlast",  {63'h0, rlast},  {63'h0, sb[0].last});
      @(negedge clock);
    end
    collect(2);

    // T6: reset mid-burst
    rready = 1'b0;
    do_read(LO, 4'hF, 8'd3, INC);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rvalid",  {63'h0, rvalid},  64'd0);
    chk("midrst_arready", {63'h0, arready}, 64'd0);
    chk("midrst_mtime",   u_dut.mtime_q,    64'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    do_read(HI, 4'h3, 8'd1, INC);
    collect(2);

    // prescaler with DIV=3
    read_div3(2);
    read_div3(7);
    read_div3(10);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
